// File: rtl/mem_stage_mq.sv
// In-order multi-entry memory stage: buffers up to DEPTH EX results, matches data
// responses to outstanding loads in order, and aligns/extends load data before WB.
module mem_stage_mq #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = 96,
  parameter int EXC_W     = 14
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          es_to_ms_valid,
  output logic                          ms_allowin,
  input  logic                          es_req,
  input  logic [2:0]                    es_ld_type,
  input  logic [$clog2(DATA_W/8)-1:0]   es_addr_lo,
  input  logic                          es_gr_we,
  input  logic [4:0]                    es_dest,
  input  logic [DATA_W-1:0]             es_alu_result,
  input  logic [EXC_W-1:0]              es_exc,
  input  logic                          es_ertn,
  input  logic [PAYLOAD_W-1:0]          es_payload,
  input  logic                          flush,
  output logic                          ms_exception,
  input  logic                          ws_allowin,
  output logic                          ms_to_ws_valid,
  output logic                          ms_to_ws_gr_we,
  output logic [4:0]                    ms_to_ws_dest,
  output logic [DATA_W-1:0]             ms_to_ws_result,
  output logic [EXC_W-1:0]              ms_to_ws_exc,
  output logic                          ms_to_ws_ertn,
  output logic [PAYLOAD_W-1:0]          ms_to_ws_payload,
  output logic [5*DEPTH-1:0]            ms_fwd_dest,
  output logic [DATA_W*DEPTH-1:0]       ms_fwd_result,
  output logic [DEPTH-1:0]              ms_fwd_ready,
  input  logic                          data_ok,
  input  logic [DATA_W-1:0]             rdata
);

  localparam int AW = $clog2(DATA_W/8);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [2:0]           ld_type;
    logic [AW-1:0]        addr_lo;
    logic                 gr_we;
    logic [4:0]           dest;
    logic [DATA_W-1:0]    alu_result;
    logic [EXC_W-1:0]     exc;
    logic                 ertn;
    logic [PAYLOAD_W-1:0] payload;
    logic [DATA_W-1:0]    rdata;
  } entry_t;

  logic [DEPTH-1:0] valid_q, valid_d, req_q, req_d, got_q, got_d;
  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d, drop_cnt_q, drop_cnt_d;

  logic             tgt_found, exc_any, resp_ok, head_byp, head_ready, push, pop;
  logic [PW-1:0]    tgt_idx, idx, fidx;
  logic [CW-1:0]    pend_cnt, drop_sum;
  logic [CW:0]      occ;
  logic [DATA_W-1:0] head_data;

  function automatic logic [DATA_W-1:0] load_ext(input logic [2:0] ld_type,
                                                 input logic [AW-1:0] addr_lo,
                                                 input logic [DATA_W-1:0] data);
    logic [DATA_W-1:0] sh_b, sh_h, sh_w;
    sh_b = data >> {addr_lo, 3'b000};
    sh_h = data >> {addr_lo[AW-1:1], 4'b0000};
    sh_w = data >> {addr_lo[AW-1], 5'b00000};
    case (ld_type)
      3'd1:    load_ext = DATA_W'($signed(sh_b[7:0]));
      3'd2:    load_ext = DATA_W'($signed(sh_h[15:0]));
      3'd3:    load_ext = DATA_W'(sh_b[7:0]);
      3'd4:    load_ext = DATA_W'(sh_h[15:0]);
      3'd5:    load_ext = (DATA_W == 64) ? DATA_W'($signed(sh_w[31:0])) : data;
      3'd6:    load_ext = (DATA_W == 64) ? DATA_W'(sh_w[31:0]) : data;
      default: load_ext = data;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] final_result(input logic req, input entry_t e,
                                                     input logic [DATA_W-1:0] data);
    final_result = req ? load_ext(e.ld_type, e.addr_lo, data) : e.alu_result;
  endfunction

  // Oldest pending request (response target), pending count and exception scan
  always_comb begin
    tgt_found = 1'b0;
    tgt_idx   = head_q;
    pend_cnt  = '0;
    exc_any   = 1'b0;
    idx       = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (valid_q[idx] && req_q[idx] && !got_q[idx]) begin
        if (!tgt_found) begin
          tgt_found = 1'b1;
          tgt_idx   = idx;
        end
        pend_cnt = pend_cnt + CW'(1);
      end
      if (valid_q[idx] && (ent_q[idx].exc != '0 || ent_q[idx].ertn)) exc_any = 1'b1;
    end
  end

  assign resp_ok    = data_ok && (drop_cnt_q == '0);
  assign head_byp   = resp_ok && tgt_found && (tgt_idx == head_q);
  assign head_ready = valid_q[head_q] && (!req_q[head_q] || got_q[head_q] || head_byp);
  assign head_data  = got_q[head_q] ? ent_q[head_q].rdata : rdata;
  assign occ        = (CW+1)'(count_q) + (CW+1)'(drop_cnt_q);

  assign ms_allowin       = (occ < (CW+1)'(DEPTH)) || flush;
  assign ms_exception     = exc_any;
  assign ms_to_ws_valid   = head_ready && !flush;
  assign ms_to_ws_gr_we   = ent_q[head_q].gr_we;
  assign ms_to_ws_dest    = ent_q[head_q].dest;
  assign ms_to_ws_result  = final_result(req_q[head_q], ent_q[head_q], head_data);
  assign ms_to_ws_exc     = ent_q[head_q].exc;
  assign ms_to_ws_ertn    = ent_q[head_q].ertn;
  assign ms_to_ws_payload = ent_q[head_q].payload;

  assign push = es_to_ms_valid && ms_allowin && !flush;
  assign pop  = ms_to_ws_valid && ws_allowin;
  assign drop_sum = drop_cnt_q + pend_cnt;

  always_comb begin
    ms_fwd_dest   = '0;
    ms_fwd_result = '0;
    ms_fwd_ready  = '0;
    fidx          = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      fidx = head_q + PW'(i);
      ms_fwd_ready[i] = valid_q[fidx] && (!req_q[fidx] || got_q[fidx]);
      ms_fwd_dest[i*5 +: 5] = (valid_q[fidx] && ent_q[fidx].gr_we) ? ent_q[fidx].dest : 5'd0;
      ms_fwd_result[i*DATA_W +: DATA_W] = final_result(req_q[fidx], ent_q[fidx], ent_q[fidx].rdata);
    end
  end

  always_comb begin
    valid_d    = valid_q;
    req_d      = req_q;
    got_d      = got_q;
    ent_d      = ent_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    if (flush) begin
      // A response arriving with the flush always pays off one owed response
      valid_d    = '0;
      head_d     = tail_q;
      count_d    = '0;
      drop_cnt_d = (data_ok && drop_sum != '0) ? drop_sum - CW'(1) : drop_sum;
    end else begin
      if (data_ok && drop_cnt_q != '0) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end else if (resp_ok && tgt_found) begin
        got_d[tgt_idx]       = 1'b1;
        ent_d[tgt_idx].rdata = rdata;
      end
      if (pop) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + PW'(1);
      end
      if (push) begin
        valid_d[tail_q]            = 1'b1;
        req_d[tail_q]              = es_req;
        got_d[tail_q]              = 1'b0;
        ent_d[tail_q].ld_type      = es_ld_type;
        ent_d[tail_q].addr_lo      = es_addr_lo;
        ent_d[tail_q].gr_we        = es_gr_we;
        ent_d[tail_q].dest         = es_dest;
        ent_d[tail_q].alu_result   = es_alu_result;
        ent_d[tail_q].exc          = es_exc;
        ent_d[tail_q].ertn         = es_ertn;
        ent_d[tail_q].payload      = es_payload;
        tail_d                     = tail_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q    <= '0;
      req_q      <= '0;
      got_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      valid_q    <= valid_d;
      req_q      <= req_d;
      got_q      <= got_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Entry payload is qualified by valid_q, so it carries no reset
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

endmodule

// File: tb/tb_mem_stage_mq.sv
// Bench for mem_stage_mq: queue-based reference model on a 32-bit instance plus
// directed scenarios, and a 64-bit instance for word loads and async reset.
module tb_mem_stage_mq;
  localparam int DW = 32, DEP = 4, PLW = 16, EW = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn = 1'b0, resetn64 = 1'b0;

  logic es_to_ms_valid, ms_allowin, es_req, es_gr_we, es_ertn, flush, ms_exception;
  logic ws_allowin, ms_to_ws_valid, ms_to_ws_gr_we, ms_to_ws_ertn, data_ok;
  logic [2:0] es_ld_type;
  logic [1:0] es_addr_lo;
  logic [4:0] es_dest, ms_to_ws_dest;
  logic [DW-1:0] es_alu_result, ms_to_ws_result, rdata;
  logic [EW-1:0] es_exc, ms_to_ws_exc;
  logic [PLW-1:0] es_payload, ms_to_ws_payload;
  logic [5*DEP-1:0] ms_fwd_dest;
  logic [DW*DEP-1:0] ms_fwd_result;
  logic [DEP-1:0] ms_fwd_ready;

  logic w_valid, w_allowin, w_req, w_gr_we, w_ertn, w_flush, w_exception;
  logic w_ws_allowin, w_to_ws_valid, w_to_ws_gr_we, w_to_ws_ertn, w_data_ok;
  logic [2:0] w_ld_type;
  logic [2:0] w_addr_lo;
  logic [4:0] w_dest, w_to_ws_dest;
  logic [63:0] w_alu_result, w_to_ws_result, w_rdata;
  logic [EW-1:0] w_exc, w_to_ws_exc;
  logic [PLW-1:0] w_payload, w_to_ws_payload;
  logic [5*DEP-1:0] w_fwd_dest;
  logic [64*DEP-1:0] w_fwd_result;
  logic [DEP-1:0] w_fwd_ready;

  mem_stage_mq #(.DATA_W(DW), .DEPTH(DEP), .PAYLOAD_W(PLW), .EXC_W(EW)) u_d32 (
    .clk(clk), .resetn(resetn), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_req(es_req), .es_ld_type(es_ld_type), .es_addr_lo(es_addr_lo), .es_gr_we(es_gr_we),
    .es_dest(es_dest), .es_alu_result(es_alu_result), .es_exc(es_exc), .es_ertn(es_ertn),
    .es_payload(es_payload), .flush(flush), .ms_exception(ms_exception), .ws_allowin(ws_allowin),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_gr_we(ms_to_ws_gr_we), .ms_to_ws_dest(ms_to_ws_dest),
    .ms_to_ws_result(ms_to_ws_result), .ms_to_ws_exc(ms_to_ws_exc), .ms_to_ws_ertn(ms_to_ws_ertn),
    .ms_to_ws_payload(ms_to_ws_payload), .ms_fwd_dest(ms_fwd_dest), .ms_fwd_result(ms_fwd_result),
    .ms_fwd_ready(ms_fwd_ready), .data_ok(data_ok), .rdata(rdata));

  mem_stage_mq #(.DATA_W(64), .DEPTH(DEP), .PAYLOAD_W(PLW), .EXC_W(EW)) u_d64 (
    .clk(clk), .resetn(resetn64), .es_to_ms_valid(w_valid), .ms_allowin(w_allowin),
    .es_req(w_req), .es_ld_type(w_ld_type), .es_addr_lo(w_addr_lo), .es_gr_we(w_gr_we),
    .es_dest(w_dest), .es_alu_result(w_alu_result), .es_exc(w_exc), .es_ertn(w_ertn),
    .es_payload(w_payload), .flush(w_flush), .ms_exception(w_exception), .ws_allowin(w_ws_allowin),
    .ms_to_ws_valid(w_to_ws_valid), .ms_to_ws_gr_we(w_to_ws_gr_we), .ms_to_ws_dest(w_to_ws_dest),
    .ms_to_ws_result(w_to_ws_result), .ms_to_ws_exc(w_to_ws_exc), .ms_to_ws_ertn(w_to_ws_ertn),
    .ms_to_ws_payload(w_to_ws_payload), .ms_fwd_dest(w_fwd_dest), .ms_fwd_result(w_fwd_result),
    .ms_fwd_ready(w_fwd_ready), .data_ok(w_data_ok), .rdata(w_rdata));

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct {
    bit req, got, we, ertn;
    bit [2:0] lt;
    bit [1:0] al;
    bit [4:0] dest;
    bit [31:0] alu, data;
    bit [13:0] exc;
    bit [15:0] pay;
  } ment_t;
  ment_t mq[$];
  int drop = 0, owed = 0;

  typedef struct packed {
    logic v, rq, we, ertn, fl, dok, wsa;
    logic [2:0] lt;
    logic [1:0] al;
    logic [4:0] dest;
    logic [31:0] alu, rd;
    logic [13:0] exc;
    logic [15:0] pay;
  } stim_t;
  stim_t s;
  bit exp_allow, exp_vld;

  function automatic bit [31:0] ref_ext(bit [2:0] lt, bit [1:0] al, bit [31:0] d);
    bit [31:0] b, h;
    b = (d >> (8 * al)) & 32'hFF;
    h = (d >> (16 * (al / 2))) & 32'hFFFF;
    case (lt)
      3'd1: return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd2: return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd3: return b;
      3'd4: return h;
      default: return d;
    endcase
  endfunction

  function automatic bit [31:0] ref_final(ment_t e, bit [31:0] d);
    return e.req ? ref_ext(e.lt, e.al, d) : e.alu;
  endfunction

  task automatic drive_inputs();
    es_to_ms_valid = s.v;  es_req = s.rq;      es_ld_type = s.lt;   es_addr_lo = s.al;
    es_gr_we = s.we;       es_dest = s.dest;   es_alu_result = s.alu;
    es_exc = s.exc;        es_ertn = s.ertn;   es_payload = s.pay;
    flush = s.fl;          data_ok = s.dok;    rdata = s.rd;        ws_allowin = s.wsa;
  endtask

  task automatic drive_check(input string tn);
    int t;
    bit hr, ex;
    ment_t h;
    bit [31:0] hd;
    bit [5*DEP-1:0] ed;
    bit [DEP-1:0] er;
    @(negedge clk);
    drive_inputs();
    #1;
    exp_allow = ((mq.size() + drop) < DEP) || s.fl;
    check({tn, "_allowin"}, ms_allowin, exp_allow);
    t = -1;
    foreach (mq[i]) if (t < 0 && mq[i].req && !mq[i].got) t = i;
    hr = 0;
    if (mq.size() > 0) hr = !mq[0].req || mq[0].got || (s.dok && drop == 0 && t == 0);
    exp_vld = hr && !s.fl;
    check({tn, "_vld"}, ms_to_ws_valid, exp_vld);
    if (exp_vld) begin
      h  = mq[0];
      hd = h.got ? h.data : s.rd;
      check({tn, "_res"}, ms_to_ws_result, ref_final(h, hd));
      check({tn, "_dest"}, ms_to_ws_dest, h.dest);
      check({tn, "_we"}, ms_to_ws_gr_we, h.we);
      check({tn, "_exc"}, ms_to_ws_exc, h.exc);
      check({tn, "_ertn"}, ms_to_ws_ertn, h.ertn);
      check({tn, "_pay"}, ms_to_ws_payload, h.pay);
    end
    ed = '0; er = '0; ex = 0;
    foreach (mq[i]) begin
      if (mq[i].we) ed[i*5 +: 5] = mq[i].dest;
      er[i] = !mq[i].req || mq[i].got;
      if (mq[i].exc != 0 || mq[i].ertn) ex = 1;
      if (er[i]) check({tn, "_fwdres"}, ms_fwd_result[i*32 +: 32], ref_final(mq[i], mq[i].data));
    end
    check({tn, "_fwddst"}, ms_fwd_dest, ed);
    check({tn, "_fwdrdy"}, ms_fwd_ready, er);
    check({tn, "_excany"}, ms_exception, ex);
  endtask

  task automatic advance();
    bit push;
    int t, l;
    ment_t e;
    push = s.v && exp_allow && !s.fl;
    if (push && s.rq) owed++;
    if (s.dok) owed--;
    if (s.fl) begin
      l = 0;
      foreach (mq[i]) if (mq[i].req && !mq[i].got) l++;
      drop = drop + l - (s.dok ? 1 : 0);
      if (drop < 0) drop = 0;
      mq.delete();
    end else begin
      if (s.dok) begin
        if (drop > 0) drop--;
        else begin
          t = -1;
          foreach (mq[i]) if (t < 0 && mq[i].req && !mq[i].got) t = i;
          if (t >= 0) begin
            mq[t].got  = 1;
            mq[t].data = s.rd;
          end
        end
      end
      if (exp_vld && s.wsa) void'(mq.pop_front());
      if (push) begin
        e.req = s.rq; e.got = 0; e.we = s.we; e.ertn = s.ertn; e.lt = s.lt; e.al = s.al;
        e.dest = s.dest; e.alu = s.alu; e.data = 0; e.exc = s.exc; e.pay = s.pay;
        mq.push_back(e);
      end
    end
    @(posedge clk);
  endtask

  task automatic set_idle();
    s = '0;
    s.wsa = 1;
  endtask

  task automatic set_ld(input bit [2:0] lt, input bit [1:0] al, input bit [4:0] dest);
    set_idle();
    s.v = 1; s.rq = 1; s.lt = lt; s.al = al; s.we = 1; s.dest = dest;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_idle();
    drive_inputs();
    resetn = 0;
    #1;
    check("rst_allowin", ms_allowin, 1);
    check("rst_vld", ms_to_ws_valid, 0);
    check("rst_exc", ms_exception, 0);
    check("rst_fwddst", ms_fwd_dest, 0);
    check("rst_fwdrdy", ms_fwd_ready, 0);
    mq.delete();
    drop = 0;
    owed = 0;
    @(negedge clk);
    resetn = 1;
  endtask

  task automatic gen_rand();
    s = '0;
    s.v = ($urandom_range(0, 3) != 0);
    if ($urandom_range(0, 15) == 0) s.exc = 14'($urandom_range(1, 16383));
    s.ertn = ($urandom_range(0, 31) == 0);
    s.rq = (s.exc == 0 && !s.ertn) && ($urandom_range(0, 2) != 0);
    s.lt = s.rq ? 3'($urandom_range(0, 4)) : 3'd0;
    s.al = 2'($urandom);
    s.we = 1'($urandom);
    s.dest = 5'($urandom);
    s.alu = $urandom;
    s.pay = 16'($urandom);
    s.fl = ($urandom_range(0, 29) == 0);
    s.dok = (owed > 0) && ($urandom_range(0, 2) != 0);
    s.rd = $urandom;
    s.wsa = ($urandom_range(0, 3) != 0);
  endtask

  task automatic w_idle();
    w_valid = 0; w_req = 0; w_ld_type = 0; w_addr_lo = 0; w_gr_we = 0; w_dest = 0;
    w_alu_result = 0; w_exc = 0; w_ertn = 0; w_payload = 0; w_flush = 0;
    w_ws_allowin = 1; w_data_ok = 0; w_rdata = 0;
  endtask

  initial begin
    set_idle();
    drive_inputs();
    w_idle();

    // Byte loads with sign / zero extension, retired in the response cycle
    do_reset();
    for (int k = 0; k < 2; k++) begin
      set_ld((k == 0) ? 3'd1 : 3'd3, 2'd3, 5'd5);
      drive_check("t1p");
      advance();
      set_idle();
      s.dok = 1; s.rd = 32'h80112233;
      drive_check("t1r");
      check("t1_vld", ms_to_ws_valid, 1);
      check("t1_res", ms_to_ws_result, (k == 0) ? 32'hFFFFFF80 : 32'h00000080);
      advance();
    end

    // Four outstanding loads, delayed responses, full queue back-pressure
    do_reset();
    for (int c = 0; c < 8; c++) begin
      set_idle();
      if (c < 4) set_ld(3'd0, 2'd0, 5'(c + 1));
      if (c >= 4) begin
        s.dok = 1;
        s.rd = 32'h1000 + 32'(c - 4);
      end
      drive_check("t2");
      if (c == 4) check("t2_full", ms_allowin, 0);
      if (c == 5) check("t2_reopen", ms_allowin, 1);
      if (c >= 4) begin
        check("t2_ord_res", ms_to_ws_result, 32'h1000 + 32'(c - 4));
        check("t2_ord_dst", ms_to_ws_dest, 5'(c - 3));
      end
      advance();
    end

    // Flush with two loads outstanding; orphaned responses are discarded
    do_reset();
    for (int c = 0; c < 10; c++) begin
      set_idle();
      case (c)
        0: set_ld(3'd0, 2'd0, 5'd1);
        1: set_ld(3'd0, 2'd0, 5'd2);
        2: begin s.v = 1; s.we = 1; s.dest = 3; s.alu = 32'h77; end
        3: s.fl = 1;
        4: set_ld(3'd0, 2'd0, 5'd9);
        5: begin s.v = 1; s.we = 1; s.dest = 10; s.alu = 32'h99; end
        6: begin s.dok = 1; s.rd = 32'hDEAD; end
        7: begin s.dok = 1; s.rd = 32'hBEEF; end
        8: begin s.dok = 1; s.rd = 32'h5; end
        default: ;
      endcase
      drive_check("t3");
      if (c == 4) begin
        check("t3_drop", u_d32.drop_cnt_q, 2);
        check("t3_empty", ms_fwd_ready, 0);
      end
      if (c == 6) check("t3_blocked", ms_allowin, 0);
      if (c == 7) check("t3_ign_vld", ms_to_ws_valid, 0);
      if (c == 8) begin
        check("t3_vld", ms_to_ws_valid, 1);
        check("t3_res", ms_to_ws_result, 32'h5);
        check("t3_dst", ms_to_ws_dest, 9);
      end
      advance();
    end

    // Flush in the same cycle as a response with three outstanding
    do_reset();
    for (int c = 0; c < 5; c++) begin
      set_idle();
      if (c < 3) set_ld(3'd0, 2'd0, 5'(c + 1));
      if (c == 3) begin s.fl = 1; s.dok = 1; s.rd = 32'h1; end
      drive_check("t4");
      if (c == 4) check("t4_drop", u_d32.drop_cnt_q, 2);
      advance();
    end

    // WB stalls while the head's data arrives; data must be held
    do_reset();
    for (int c = 0; c < 7; c++) begin
      set_idle();
      if (c == 0) set_ld(3'd2, 2'd2, 5'd7);
      if (c == 1) begin s.dok = 1; s.rd = 32'hABCD1234; end
      if (c >= 1 && c <= 5) s.wsa = 0;
      drive_check("t5");
      if (c >= 1 && c <= 5) begin
        check("t5_hold_vld", ms_to_ws_valid, 1);
        if (c >= 2) check("t5_fwdrdy", ms_fwd_ready[0], 1);
      end
      if (c == 6) check("t5_res", ms_to_ws_result, 32'hFFFFABCD);
      advance();
    end

    // Randomized traffic against the reference model
    do_reset();
    repeat (3000) begin
      gen_rand();
      drive_check("rnd");
      advance();
    end

    // 64-bit word loads and asynchronous reset
    @(negedge clk);
    resetn64 = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      w_idle();
      w_valid = 1; w_req = 1; w_ld_type = (k == 0) ? 3'd5 : 3'd6; w_addr_lo = 3'd4;
      w_gr_we = 1; w_dest = 5'd3;
      @(negedge clk);
      w_idle();
      w_data_ok = 1; w_rdata = 64'h87654321_00000000;
      #1;
      check("t6_vld", w_to_ws_valid, 1);
      check("t6_res", w_to_ws_result, (k == 0) ? 64'hFFFFFFFF87654321 : 64'h0000000087654321);
    end
    @(negedge clk);
    w_idle();
    w_valid = 1; w_exc = 14'h1; w_gr_we = 1; w_dest = 5'd4; w_alu_result = 64'h42;
    @(negedge clk);
    w_idle();
    w_ws_allowin = 0;
    w_valid = 1; w_req = 1; w_ld_type = 3'd5; w_gr_we = 1; w_dest = 5'd3;
    @(negedge clk);
    w_idle();
    w_ws_allowin = 0;
    #1;
    check("t6_pre_exc", w_exception, 1);
    check("t6_pre_fwddst", w_fwd_dest, 20'h00064);
    check("t6_pre_allow", w_allowin, 1);
    #2;
    resetn64 = 0;
    #1;
    check("t6_ar_allowin", w_allowin, 1);
    check("t6_ar_vld", w_to_ws_valid, 0);
    check("t6_ar_exc", w_exception, 0);
    check("t6_ar_fwddst", w_fwd_dest, 0);
    check("t6_ar_fwdrdy", w_fwd_ready, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
